// File: rtl/im_loader.sv
// im_loader: byte-stream instruction-memory loader for SISC.
// Assembles big-endian words and holds the CPU in reset until loaded.
module im_loader #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter logic [16:0] MAX_WORDS = 17'h10000
) (
  input  logic        clk,
  input  logic        rst_f,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        im_we,
  output logic [15:0] im_addr,
  output logic [31:0] im_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR0,
    S_HDR1,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t      state_q, state_d;
  logic        in_ready_q, in_ready_d;
  logic        im_we_q, im_we_d;
  logic [15:0] im_addr_q, im_addr_d;
  logic [31:0] im_wdata_q, im_wdata_d;
  logic        cpu_hold_q, cpu_hold_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_hi_q, cnt_hi_d;
  logic [16:0] rem_q, rem_d;
  logic [1:0]  idx_q, idx_d;
  logic [23:0] asm_q, asm_d;

  logic        xfer;
  logic [15:0] hdr_n;

  assign xfer  = in_valid & in_ready_q;
  assign hdr_n = {cnt_hi_q, in_data};

  // Next-state and datapath; outputs are derived from the next state
  // so that every port comes straight from a flop.
  always_comb begin
    state_d    = state_q;
    im_addr_d  = im_addr_q;
    im_wdata_d = im_wdata_q;
    cnt_hi_d   = cnt_hi_q;
    rem_d      = rem_q;
    idx_d      = idx_q;
    asm_d      = asm_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_HDR0;
      end
      S_HDR0: begin
        if (xfer) begin
          cnt_hi_d = in_data;
          state_d  = S_HDR1;
        end
      end
      S_HDR1: begin
        if (xfer) begin
          im_addr_d = BASE_ADDR;
          idx_d     = 2'd0;
          rem_d     = {1'b0, hdr_n};
          if (hdr_n == 16'd0)
            state_d = S_DONE;
          else if ({1'b0, hdr_n} > MAX_WORDS)
            state_d = S_ERR;
          else
            state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer) begin
          idx_d = idx_q + 2'd1;
          asm_d = {asm_q[15:0], in_data};
          if (idx_q == 2'd3) begin
            im_wdata_d = {asm_q, in_data};
            state_d    = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        im_addr_d = im_addr_q + 16'd1;
        rem_d     = rem_q - 17'd1;
        if (rem_q == 17'd1)
          state_d = S_DONE;
        else
          state_d = S_DATA;
      end
      S_DONE, S_ERR: begin
        if (start) state_d = S_HDR0;
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d = (state_d == S_HDR0) ||
                 (state_d == S_HDR1) ||
                 (state_d == S_DATA);
    im_we_d    = (state_d == S_WRITE);
    cpu_hold_d = (state_d != S_DONE);
    done_d     = (state_d == S_DONE);
    err_d      = (state_d == S_ERR);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst_f) begin
    if (rst_f) begin
      state_q    <= S_IDLE;
      in_ready_q <= 1'b0;
      im_we_q    <= 1'b0;
      im_addr_q  <= BASE_ADDR;
      im_wdata_q <= 32'h0;
      cpu_hold_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cnt_hi_q   <= 8'h0;
      rem_q      <= 17'h0;
      idx_q      <= 2'd0;
      asm_q      <= 24'h0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      im_we_q    <= im_we_d;
      im_addr_q  <= im_addr_d;
      im_wdata_q <= im_wdata_d;
      cpu_hold_q <= cpu_hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
      cnt_hi_q   <= cnt_hi_d;
      rem_q      <= rem_d;
      idx_q      <= idx_d;
      asm_q      <= asm_d;
    end
  end

  assign in_ready = in_ready_q;
  assign im_we    = im_we_q;
  assign im_addr  = im_addr_q;
  assign im_wdata = im_wdata_q;
  assign cpu_hold = cpu_hold_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: doc/im_loader.md
# im_loader

Instruction-memory loader for the SISC system. It accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and writes them into instruction memory at consecutive 16-bit word addresses. It holds the processor in reset until the image is fully written. The SISC core only reads instruction memory; this block is the write side of that interface and sits beside `im` on its write port.

## Interface
- `BASE_ADDR`, default 16'h0000: word address of the first instruction written.
- `MAX_WORDS`, default 17'h10000: largest legal word count. Must be ≤ 2^16 and ≤ (2^16 − `BASE_ADDR`).
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_f`  in  1  reset, asynchronous and active-high.
- `start`  in  1  level-sampled request to begin a load.
- `in_valid`  in  1  source has a byte on `in_data`.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `im_we`  out  1  instruction-memory write strobe, one-cycle pulse.
- `im_addr`  out  16  instruction-memory write word address.
- `im_wdata`  out  32  instruction word to write.
- `cpu_hold`  out  1  forces the processor into reset while high.
- `done`  out  1  sticky: the image loaded successfully.
- `err`  out  1  sticky: the header count exceeded `MAX_WORDS`.

## Operation
- **Stream format:**
  - Header: 2 bytes, word count N, big-endian, high byte first.
  - Payload: 4·N bytes, each word big-endian (the byte sent first is bits 31:24).
- **Transfer rule:** a byte transfers only when `in_valid & in_ready` is high at a rising edge.
- **Registered outputs:** all outputs are registered.
- **Reset values:** `in_ready`=0, `im_we`=0, `im_addr`=`BASE_ADDR`, `im_wdata`=0, `cpu_hold`=1, `done`=0, `err`=0. State goes to IDLE.
- **State machine:**
  - IDLE: `in_ready`=0. If `start`=1 → HDR0, and clear `done`/`err`.
  - HDR0: `in_ready`=1. On transfer, latch N[15:8] → HDR1.
  - HDR1: `in_ready`=1. On transfer, latch N[7:0]; set `im_addr`=`BASE_ADDR` and the byte index to 0.
    - If N=0 → DONE.
    - If N > `MAX_WORDS` → ERR.
    - Otherwise → DATA.
  - DATA: `in_ready`=1. Each transfer shifts the byte into the word assembly register and increments the 2-bit byte index. On the 4th byte, latch the full word into `im_wdata` → WRITE.
  - WRITE: `in_ready`=0 and `im_we`=1 for exactly this cycle, with `im_addr`/`im_wdata` stable. On exit, increment `im_addr` and decrement the remaining count.
    - If remaining becomes 0 → DONE.
    - Otherwise → DATA.
  - DONE: `in_ready`=0, `done`=1, `cpu_hold`=0. If `start`=1 → HDR0, with `cpu_hold`=1 and `done` cleared.
  - ERR: `in_ready`=0, `err`=1, `cpu_hold` stays 1, no writes. If `start`=1 → HDR0, clearing `err`.
- **`cpu_hold`:** 1 in every state except DONE.
- **`start`:** ignored in HDR0, HDR1, DATA and WRITE.
- **Address arithmetic:** `im_addr` is 16-bit and increments by 1 per word. The `MAX_WORDS` rule guarantees it never wraps within a load. The remaining count is 17 bits.
- **Source stalls:** `in_valid` low mid-word stalls without loss. The partial word, byte index and address are held.
- **Reset mid-load:** asynchronous reset forces the reset values immediately. A partially assembled word is discarded, and words already written stay in memory.

## Timing
- **Start:** `start` sampled high in IDLE → `in_ready` is 1 the next cycle.
- **Per-word latency:** the 4th byte transfers at edge k; `im_we`=1 during cycle k→k+1; `in_ready` returns at k+1.
- **Throughput:** best case is 5 cycles per word, 2 + 5·N cycles for a full load after `start`.
- **Completion:** `done` rises and `cpu_hold` falls on the edge that leaves WRITE for the final word. For N=0 this is the edge after the HDR1 transfer.
- **No back-to-back writes:** `im_we` is never high on two consecutive cycles.

## Test plan
- **Reset:** assert `rst_f` mid-cycle → outputs take reset values without waiting for a clock edge; `cpu_hold`=1, `im_addr`=16'h0000.
- **Two-word load:** `start`, then bytes 00 02 | 12 34 56 78 | 9A BC DE F0 with `in_valid` always high → two `im_we` pulses:
  - addr 0000, data 12345678;
  - addr 0001, data 9ABCDEF0.
  - Then `done`=1 and `cpu_hold`=0, 12 cycles after `start`.
- **Stalls:** same stream with `in_valid` low for 3 cycles after each of bytes 2, 5 and 9 → identical writes, no extra `im_we`, `in_ready` stays high during the stalls.
- **Empty image:** header 00 00 → no `im_we`, `done`=1 one cycle after the second header byte.
- **Oversize header:** with `MAX_WORDS`=4, header 00 05 → `err`=1, `in_ready`=0, `cpu_hold`=1, no writes. A subsequent `start` followed by a one-word image (00 01 …) → `err` clears and `done`=1.
- **Reset mid-load:** reset after byte 3 of word 2 of a 3-word image → first word written, no further `im_we`. A new `start` reloads from `BASE_ADDR`.
